// File: rtl/servo_pos_arbiter.sv
// Two-requester servo position arbiter: frame-aligned grants, rate-limited moves, registered PWM.
// Optional build macro SERVO_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: A wins ties).
module servo_pos_arbiter #(
    parameter int FRAME_TICKS = 20000,
    parameter int PULSE_MIN   = 400,
    parameter int CTRL_MAX    = 2200,
    parameter int STEP        = 10
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [11:0] tgt_a,
    input  logic [11:0] tgt_b,
    input  logic        freeze,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done,
    output logic        busy,
    output logic [11:0] control,
    output logic        servo
);

    localparam int              CW         = (FRAME_TICKS > 2) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(FRAME_TICKS - 1);
    localparam logic [11:0]     CTRL_MAX_V = 12'(CTRL_MAX);
    localparam logic [11:0]     STEP_V     = 12'(STEP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_MOVE  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [11:0]   control_q, control_d;
    logic [11:0]   target_q, target_d;
    logic          servo_q, servo_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          boundary_s;
    logic          win_b_s;
    logic [11:0]   next_ctrl_s;
    logic [31:0]   pulse_end_s;
`ifdef SERVO_ARB_ROUND_ROBIN_EN
    logic          last_b_q, last_b_d;
`endif

    function automatic logic [11:0] clamp_ctrl(input logic [11:0] v);
        if (v > CTRL_MAX_V) begin
            clamp_ctrl = CTRL_MAX_V;
        end else begin
            clamp_ctrl = v;
        end
    endfunction

    // Move at most STEP toward tgt; the guarded +/- can never wrap 12 bits.
    function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
        if (tgt > cur) begin
            if ((tgt - cur) <= STEP_V) begin
                step_toward = tgt;
            end else begin
                step_toward = cur + STEP_V;
            end
        end else begin
            if ((cur - tgt) <= STEP_V) begin
                step_toward = tgt;
            end else begin
                step_toward = cur - STEP_V;
            end
        end
    endfunction

    // Next-state, arbitration and datapath logic.
    always_comb begin
        boundary_s  = (cnt_q == {CW{1'b0}});
        cnt_d       = (cnt_q == CNT_LAST) ? {CW{1'b0}} : cnt_q + CW'(1'b1);
        pulse_end_s = 32'(PULSE_MIN) + {20'd0, control_q};
        servo_d     = (32'(cnt_q) < pulse_end_s);
        next_ctrl_s = step_toward(control_q, target_q);
`ifdef SERVO_ARB_ROUND_ROBIN_EN
        win_b_s     = req_b & (~req_a | ~last_b_q);
        last_b_d    = last_b_q;
`else
        win_b_s     = req_b & ~req_a;
`endif
        state_d     = state_q;
        control_d   = control_q;
        target_d    = target_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (boundary_s && (req_a || req_b)) begin
                    state_d  = S_GRANT;
                    target_d = clamp_ctrl(win_b_s ? tgt_b : tgt_a);
                    gnt_a_d  = ~win_b_s;
                    gnt_b_d  = win_b_s;
`ifdef SERVO_ARB_ROUND_ROBIN_EN
                    last_b_d = win_b_s;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                state_d = S_MOVE;
            end
            S_MOVE: begin
                // A zero-length move still waits for a boundary before completing.
                if (boundary_s && !freeze) begin
                    control_d = next_ctrl_s;
                    if (next_ctrl_s == target_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MOVE;
                    end
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_MOVE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt_q     <= {CW{1'b0}};
            state_q   <= S_IDLE;
            control_q <= 12'd0;
            target_q  <= 12'd0;
            servo_q   <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SERVO_ARB_ROUND_ROBIN_EN
            last_b_q  <= 1'b1;
`endif
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            control_q <= control_d;
            target_q  <= target_d;
            servo_q   <= servo_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef SERVO_ARB_ROUND_ROBIN_EN
            last_b_q  <= last_b_d;
`endif
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign control = control_q;
    assign servo   = servo_q;

endmodule

// File: doc/servo_pos_arbiter.md
SERVO_POS_ARBITER -- requirements
Module: servo_pos_arbiter

Interface
REQ-001 SHALL have parameter FRAME_TICKS, default 20000, meaning mclk cycles per servo frame (20 ms at 1 MHz).
REQ-002 SHALL have parameter PULSE_MIN, default 400, meaning pulse width in ticks at control = 0.
REQ-003 SHALL have parameter CTRL_MAX, default 2200, meaning the upper clamp for the control value.
REQ-004 SHALL have parameter STEP, default 10, meaning the maximum control change per frame.
REQ-005 SHALL have port mclk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports req_a / req_b  in  1  position requests from requester A / B, level, held until granted.
REQ-008 SHALL have ports tgt_a / tgt_b  in  12  target control values of A / B, sampled only at grant.
REQ-009 SHALL have port freeze  in  1  holds control at its current value while high.
REQ-010 SHALL have ports gnt_a / gnt_b  out  1  one-cycle grant pulses.
REQ-011 SHALL have port done  out  1  one-cycle pulse when the granted move completes.
REQ-012 SHALL have port busy  out  1  high in MOVE state.
REQ-013 SHALL have port control  out  12  current position command.
REQ-014 SHALL have port servo  out  1  registered PWM output.

Function
REQ-015 Frame counter SHALL count 0..FRAME_TICKS-1 and wrap to 0; frame boundary = counter == 0.
REQ-016 servo SHALL be registered high on the cycle after any counter value satisfying counter < PULSE_MIN + control, and low otherwise; fixed 1-cycle latency.
REQ-017 FSM states SHALL be IDLE, GRANT, MOVE, DONE.
REQ-018 IDLE -> GRANT SHALL occur at a frame boundary when req_a or req_b is high; requests arriving off-boundary wait for the next boundary.
REQ-019 In GRANT (one cycle), the FSM SHALL pulse gnt of the winner, latch its tgt clamped to CTRL_MAX into target, record the winner as last, and go to MOVE.
REQ-020 Simultaneous req_a and req_b SHALL be resolved per REQ-031/REQ-032.
REQ-021 In MOVE, at each frame boundary with freeze low, control SHALL move toward target by STEP, landing exactly on target if |target - control| <= STEP.
REQ-022 The FSM SHALL transition MOVE -> DONE on the cycle control equals target; target == control at grant SHALL reach DONE at the next boundary without changing control.
REQ-023 DONE SHALL pulse done for one cycle, then go to IDLE; a new grant SHALL be possible no earlier than the next boundary.
REQ-024 With freeze high, control SHALL be unchanged at every boundary, and the FSM SHALL remain in its state; IDLE still grants, but MOVE does not step.
REQ-025 Requests during GRANT, MOVE or DONE SHALL be ignored and not queued; requesters hold req.
REQ-026 The arithmetic SHALL never underflow below 0 or exceed CTRL_MAX (12-bit unsigned).

Reset
REQ-027 On rst high, counter, servo, control, gnt_a, gnt_b, done and busy SHALL go to 0 immediately, and state SHALL go to IDLE, independent of mclk.
REQ-028 On rst high, target SHALL go to 0 and last SHALL go to B, so A wins the first tie.
REQ-029 rst mid-MOVE SHALL abandon the move, leaving no pending grant after release.
REQ-030 The first boundary after release SHALL be the first rising edge with rst low.

Configuration
REQ-031 With macro SERVO_ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester that is not last.
REQ-032 Without SERVO_ARB_ROUND_ROBIN_EN, A SHALL always win ties (fixed priority), and last SHALL be unused.

Verification
REQ-033 Reset release, req_a=1, tgt_a=100 -> gnt_a at frame 0, control 10,20..100 over 10 frames, done pulse, servo high 500 ticks.
REQ-034 tgt_a=4000 -> target clamped to 2200; control stops at 2200; servo high 2600 ticks.
REQ-035 control=100, req_b tgt_b=95 -> single step to 95, done next frame.
REQ-036 req_a and req_b held together, SERVO_ARB_ROUND_ROBIN_EN defined -> grants A, B, A alternate; macro undefined -> A only.
REQ-037 freeze=1 for 3 frames mid-move at control=50 -> control stays 50, busy stays 1, and the move resumes after freeze drops.
REQ-038 rst pulse mid-move at control=60 -> control=0, servo=0, state IDLE, no done.
